// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic two-entry pipeline stage register with flush, kill nulling and stall counter
module pipe_stage_reg #(
    parameter int DATA_W    = 96,
    parameter int EXC_W     = 5,
    parameter int KILL_CODE = 10,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_instr,
    input  logic              in_bd,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic              out_bd,
    output logic [EXC_W-1:0]  out_exc,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       instr;
        logic              bd;
        logic [EXC_W-1:0]  exc;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    entry_t            head_q, head_d;
    entry_t            skid_q, skid_d;
    entry_t            in_entry;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              accept;
    logic              pop;

    // in_ready decodes only the state register, so out_ready never reaches it
    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        in_entry.pc    = in_pc;
        in_entry.instr = in_instr;
        in_entry.bd    = in_bd;
        in_entry.exc   = in_exc;
        in_entry.data  = in_data;
        if (in_exc == EXC_W'(KILL_CODE)) begin
            in_entry.instr = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    head_d  = in_entry;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    head_d = in_entry;
                end else if (accept) begin
                    state_d = TWO;
                    skid_d  = in_entry;
                end else if (pop) begin
                    state_d = EMPTY;
                    head_d  = '0;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d = ONE;
                    head_d  = skid_q;
                    skid_d  = '0;
                end
            end
            default: begin
                state_d = EMPTY;
                head_d  = '0;
                skid_d  = '0;
            end
        endcase
        if (flush) begin
            state_d = EMPTY;
            head_d  = '0;
            skid_d  = '0;
        end
    end

    // Stall counter survives flush so redirect storms stay visible
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

    assign out_pc    = out_valid ? head_q.pc    : '0;
    assign out_instr = out_valid ? head_q.instr : '0;
    assign out_bd    = out_valid ? head_q.bd    : 1'b0;
    assign out_exc   = out_valid ? head_q.exc   : '0;
    assign out_data  = out_valid ? head_q.data  : '0;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg
module tb_pipe_stage_reg;

    localparam int DATA_W = 96;
    localparam int EXC_W  = 5;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       instr;
        logic              bd;
        logic [EXC_W-1:0]  exc;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset, flush, in_valid, in_ready, in_bd;
    logic [31:0]       in_pc, in_instr;
    logic [EXC_W-1:0]  in_exc;
    logic [DATA_W-1:0] in_data;
    logic              out_valid, out_ready, out_bd;
    logic [31:0]       out_pc, out_instr;
    logic [EXC_W-1:0]  out_exc;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;

    int     n_cmp = 0;
    int     n_err = 0;
    bit     chk_en = 1'b0;
    beat_t  exp_q[$];
    int     exp_stall = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DATA_W), .EXC_W(EXC_W), .KILL_CODE(10), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_bd(in_bd), .in_exc(in_exc), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_bd(out_bd), .out_exc(out_exc), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a two-deep FIFO advanced on every clock edge
    always @(posedge clk) begin
        beat_t b;
        bit    vld, acc, pp;
        if (reset) begin
            exp_q.delete();
            exp_stall = 0;
        end else begin
            vld = (exp_q.size() > 0);
            if (vld && !out_ready && exp_stall < (1 << CNT_W) - 1) exp_stall++;
            if (flush) begin
                exp_q.delete();
            end else begin
                acc = in_valid && (exp_q.size() < 2);
                pp  = vld && out_ready;
                if (pp) void'(exp_q.pop_front());
                if (acc) begin
                    b.pc    = in_pc;
                    b.instr = (in_exc == 5'd10) ? 32'h0 : in_instr;
                    b.bd    = in_bd;
                    b.exc   = in_exc;
                    b.data  = in_data;
                    exp_q.push_back(b);
                end
            end
        end
    end

    always @(negedge clk) begin
        beat_t hd;
        if (chk_en) begin
            hd = (exp_q.size() > 0) ? exp_q[0] : '0;
            chk("out_valid", 128'(out_valid), 128'(exp_q.size() > 0));
            chk("in_ready",  128'(in_ready),  128'(exp_q.size() < 2));
            chk("out_pc",    128'(out_pc),    128'(hd.pc));
            chk("out_instr", 128'(out_instr), 128'(hd.instr));
            chk("out_bd",    128'(out_bd),    128'(hd.bd));
            chk("out_exc",   128'(out_exc),   128'(hd.exc));
            chk("out_data",  128'(out_data),  128'(hd.data));
            chk("stall_cnt", 128'(stall_cnt), 128'(exp_stall));
        end
    end

    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic bd, input logic [EXC_W-1:0] exc,
                        input logic ordy, input logic fl, input logic rst);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        in_bd     = bd;
        in_exc    = exc;
        in_data   = {$urandom, $urandom, $urandom};
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk_en = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_stall", 128'(stall_cnt), 128'(0));

        // Streaming at full rate
        step(1, 32'h3000, 32'h1111_0000, 0, 0, 1, 0, 0);
        chk("stream_pc0", 128'(out_pc), 128'(32'h3000));
        step(1, 32'h3004, 32'h1111_0004, 0, 0, 1, 0, 0);
        chk("stream_pc1", 128'(out_pc), 128'(32'h3004));
        step(1, 32'h3008, 32'h1111_0008, 0, 0, 1, 0, 0);
        chk("stream_pc2", 128'(out_pc), 128'(32'h3008));
        step(0, 0, 0, 0, 0, 1, 0, 0);

        // Backpressure fills both entries
        step(1, 32'h3000, 32'h2222_0000, 0, 0, 0, 0, 0);
        step(1, 32'h3004, 32'h2222_0004, 0, 0, 0, 0, 0);
        chk("bp_in_ready", 128'(in_ready), 128'(0));
        chk("bp_hold_pc", 128'(out_pc), 128'(32'h3000));
        step(1, 32'h3008, 32'h2222_0008, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        chk("bp_order_pc", 128'(out_pc), 128'(32'h3004));
        step(0, 0, 0, 0, 0, 1, 0, 0);

        // Kill nulling and pass-through
        step(1, 32'h3010, 32'hFC00_0000, 1, 5'd10, 1, 0, 0);
        chk("kill_instr", 128'(out_instr), 128'(0));
        chk("kill_bd", 128'(out_bd), 128'(1));
        step(1, 32'h3014, 32'hFC00_0000, 0, 5'd4, 1, 0, 0);
        chk("nokill_instr", 128'(out_instr), 128'(32'hFC00_0000));
        step(0, 0, 0, 0, 0, 1, 0, 0);

        // Flush while full, beat offered alongside is discarded
        step(1, 32'h3018, 32'h3333_0000, 0, 0, 0, 0, 0);
        step(1, 32'h301C, 32'h3333_0004, 0, 0, 0, 0, 0);
        step(1, 32'h3020, 32'h3333_0008, 0, 0, 0, 1, 0);
        chk("flush_valid", 128'(out_valid), 128'(0));
        chk("flush_ready", 128'(in_ready), 128'(1));
        step(0, 0, 0, 0, 0, 1, 0, 0);

        // Saturation
        step(1, 32'h3024, 32'h4444_0000, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("sat_stall", 128'(stall_cnt), 128'(15));
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("sat_hold", 128'(stall_cnt), 128'(15));

        // Reset and flush together while holding
        step(1, 32'h3028, 32'h5555_0000, 0, 0, 0, 1, 1);
        chk("rstfl_valid", 128'(out_valid), 128'(0));
        chk("rstfl_stall", 128'(stall_cnt), 128'(0));

        // Random traffic with occasional flush
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
                 5'($urandom_range(8, 12)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 31) == 0), 0);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 0, 0);
        chk("drain_valid", 128'(out_valid), 128'(0));

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, elastic pipeline-stage register that replaces the fixed ID/EX-style latches between any two CPU stages.
- Carries a per-instruction bundle (pc, instr, branch-delay flag, exception code, generic payload) across a valid/ready handshake.
- Uses a 2-entry skid buffer, so in_ready is registered and backpressure does not create a combinational path.
- Supports synchronous flush (interrupt/eret), nulling of the instruction field on a kill exception code, and a saturating backpressure-cycle counter.

Parameters:
DATA_W, 96, width of generic payload (e.g. imm32 + rs + rt).
EXC_W, 5, exception code width.
KILL_CODE, 10, exception code whose instruction field is forced to 0 on capture (reserved instruction).
CNT_W, 16, width of the stall counter.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
flush  in  1  synchronous clear of all held entries (IRQ/exception redirect).
in_valid  in  1  upstream beat valid.
in_ready  out  1  stage can accept a beat; registered.
in_pc  in  32  instruction address.
in_instr  in  32  instruction word.
in_bd  in  1  branch-delay-slot flag.
in_exc  in  EXC_W  exception code (0 = none).
in_data  in  DATA_W  generic payload.
out_valid  out  1  head entry valid.
out_ready  in  1  downstream accepts head.
out_pc  out  32  head pc.
out_instr  out  32  head instruction.
out_bd  out  1  head delay-slot flag.
out_exc  out  EXC_W  head exception code.
out_data  out  DATA_W  head payload.
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Reset (clk, synchronous, active-high):
  - State goes to EMPTY; both entries are cleared.
  - out_valid=0, all out_* fields=0, in_ready=1, stall_cnt=0.
- Storage: head entry H and skid entry S. States:
  - EMPTY (no entries valid).
  - ONE (H valid).
  - TWO (H and S valid).
- Handshake:
  - Accept = in_valid & in_ready.
  - Pop = out_valid & out_ready.
  - in_ready = (state != TWO). It is a registered value, not a function of out_ready.
- Transitions, evaluated each clock when reset=0 and flush=0:
  - EMPTY: accept -> ONE, H takes the input.
  - ONE, accept & pop: stay in ONE, H takes the input.
  - ONE, accept only: -> TWO, S takes the input.
  - ONE, pop only: -> EMPTY.
  - TWO, pop: -> ONE, H takes S. No accept is possible in TWO.
- Ordering: strictly FIFO. No beat is dropped or duplicated except on flush.
- Latency: a beat accepted at edge N is visible on out_* after edge N when the stage was empty. Throughput is one beat per cycle when out_ready is held at 1.
- Kill nulling:
  - On capture, if in_exc == KILL_CODE, the stored instr = 0 (nop).
  - pc, bd, exc and data are stored unchanged, so EPC and the delay-slot flag stay correct.
- Empty outputs: whenever out_valid=0, all out_* fields read 0. Downstream sees a nop with pc=0.
- Flush (reset=0):
  - Next state is EMPTY and all entries are zeroed.
  - Any beat presented in the same cycle is discarded, even if in_ready=1.
  - in_ready=1 on the following cycle.
- Priority: reset > flush > normal operation.
- stall_cnt:
  - Increments by 1 on each edge where out_valid=1 and out_ready=0.
  - Holds at 2^CNT_W-1 when saturated.
  - Cleared by reset only; unaffected by flush.
- Holding: while out_valid=1 and out_ready=0, all out_* fields remain stable.

Test Plan:
- Reset, then stream pc=0x3000, 0x3004, 0x3008 with out_ready=1 -> out_pc shows each value exactly one cycle after acceptance; in_ready stays 1; stall_cnt=0.
- Backpressure: out_ready=0, push pc=0x3000 then 0x3004 -> after the second accept in_ready=0 and out_pc holds 0x3000. Release out_ready -> 0x3000 then 0x3004 emerge in order. stall_cnt equals the number of edges with out_ready=0 while valid.
- Kill: push instr=0xFC000000, in_exc=10, pc=0x3010, bd=1 -> out_instr=0, out_pc=0x3010, out_bd=1, out_exc=10. With in_exc=4 the instr passes through unchanged.
- Flush in state TWO with in_valid=1, in_pc=0x3020 -> next cycle out_valid=0, all out_* fields=0, in_ready=1. 0x3020 never appears; stall_cnt is retained.
- Reset and flush asserted together while holding data -> everything zeroed, stall_cnt=0.
- Saturation with CNT_W=4: hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 and stays at 15.
